// File: rtl/vx_wb_commit_pkg.sv
// Shared types for the writeback commit stage: beat layout, FSM states and
// default widths for the build-wide macros when the build does not supply them.
`ifndef NUM_THREADS
`define NUM_THREADS 2
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef NR_BITS
`define NR_BITS 5
`endif
`ifndef UUID_WIDTH
`define UUID_WIDTH 8
`endif
`ifndef STALL_TIMEOUT
`define STALL_TIMEOUT 256
`endif

package vx_wb_commit_pkg;

  localparam int ISSUE_WIS_W  = 2;
  localparam int THREAD_CNT_P = `NUM_THREADS;
  localparam int XLEN_P       = `XLEN;
  localparam int NR_BITS_P    = `NR_BITS;
  localparam int UUID_W_P     = `UUID_WIDTH;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } commit_state_e;

  // One result beat as carried from an execute unit to the writeback port.
  typedef struct packed {
    logic [UUID_W_P-1:0]            uuid;
    logic [ISSUE_WIS_W-1:0]         wis;
    logic [THREAD_CNT_P-1:0]        tmask;
    logic [XLEN_P-1:0]              pc;
    logic                           wb;
    logic [NR_BITS_P-1:0]           rd;
    logic [THREAD_CNT_P*XLEN_P-1:0] data;
    logic                           sop;
    logic                           eop;
  } wb_beat_t;

  localparam int WB_BEAT_W = $bits(wb_beat_t);

  // Index width that stays legal for a single source.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_rr_grant.sv
// Round-robin grant picker. Purely combinational: while locked the grant is
// pinned to lock_idx; otherwise the first requester at or after ptr wins,
// and with no requester the grant parks on ptr.
module vx_rr_grant #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             lock,
  input  logic [IDX_W-1:0] lock_idx,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic found;

  // Cyclic search: indices >= ptr first, then the wrapped part below ptr.
  always_comb begin
    grant_idx = ptr;
    found     = 1'b0;
    grant     = '0;
    if (lock) begin
      grant_idx = lock_idx;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (IDX_W'(i) >= ptr)) begin
          grant_idx = IDX_W'(i);
          found     = 1'b1;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (!found && req[i] && (IDX_W'(i) < ptr)) begin
          grant_idx = IDX_W'(i);
          found     = 1'b1;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      grant[i] = (grant_idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/vx_wb_commit.sv
// Writeback commit: arbitrates result beats from NUM_SRC execute units onto
// one registered writeback stream. Multi-beat packets hold the grant until
// their eop beat so packets never interleave.
// Optional macro VX_WB_COMMIT_PERF_EN adds perf_commits / perf_conflicts.
//
// state     | meaning
// ST_IDLE   | no packet open; round-robin grant from rr_ptr
// ST_LOCKED | packet open on lock_idx; only that source is ready
module vx_wb_commit
  import vx_wb_commit_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int THREAD_CNT = `NUM_THREADS,
  parameter int WIS_W      = ISSUE_WIS_W,
  parameter int UUID_W     = `UUID_WIDTH
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [NUM_SRC-1:0]                src_valid,
  output logic [NUM_SRC-1:0]                src_ready,
  input  logic [NUM_SRC*UUID_W-1:0]         src_uuid,
  input  logic [NUM_SRC*WIS_W-1:0]          src_wis,
  input  logic [NUM_SRC*THREAD_CNT-1:0]     src_tmask,
  input  logic [NUM_SRC*`XLEN-1:0]          src_pc,
  input  logic [NUM_SRC-1:0]                src_wb,
  input  logic [NUM_SRC*`NR_BITS-1:0]       src_rd,
  input  logic [NUM_SRC*THREAD_CNT*`XLEN-1:0] src_data,
  input  logic [NUM_SRC-1:0]                src_sop,
  input  logic [NUM_SRC-1:0]                src_eop,
  output logic                              wb_valid,
  output logic [UUID_W-1:0]                 wb_uuid,
  output logic [WIS_W-1:0]                  wb_wis,
  output logic [THREAD_CNT-1:0]             wb_tmask,
  output logic [`XLEN-1:0]                  wb_pc,
  output logic [`NR_BITS-1:0]               wb_rd,
  output logic [THREAD_CNT*`XLEN-1:0]       wb_data,
  output logic                              wb_sop,
  output logic                              wb_eop
`ifdef VX_WB_COMMIT_PERF_EN
  ,
  output logic [43:0]                       perf_commits,
  output logic [43:0]                       perf_conflicts
`endif
);

  localparam int IDX_W = idx_width(NUM_SRC);

  commit_state_e          state_q, state_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]       lock_idx_q, lock_idx_d;
  logic [IDX_W-1:0]       grant_idx;
  logic [NUM_SRC-1:0]     grant;
  logic                   fire;
  wb_beat_t               src_beat [NUM_SRC];
  logic [WB_BEAT_W-1:0]   sel_bits;
  wb_beat_t               sel_beat;
  wb_beat_t               beat_q;
  logic                   beat_vld_q;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign src_beat[g] = {src_uuid[g*UUID_W +: UUID_W],
                          src_wis[g*WIS_W +: WIS_W],
                          src_tmask[g*THREAD_CNT +: THREAD_CNT],
                          src_pc[g*`XLEN +: `XLEN],
                          src_wb[g],
                          src_rd[g*`NR_BITS +: `NR_BITS],
                          src_data[g*THREAD_CNT*`XLEN +: THREAD_CNT*`XLEN],
                          src_sop[g],
                          src_eop[g]};
  end

  vx_rr_grant #(
    .N     (NUM_SRC),
    .IDX_W (IDX_W)
  ) u_rr_grant (
    .req       (src_valid),
    .ptr       (rr_ptr_q),
    .lock      (state_q == ST_LOCKED),
    .lock_idx  (lock_idx_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Ready follows the grant only; it never depends on a non-granted source's valid.
  assign src_ready = grant & {NUM_SRC{reset_n}};
  assign fire      = |(src_valid & src_ready);

  // One-hot AND-OR mux of the granted source's beat.
  always_comb begin
    sel_bits = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_bits = sel_bits | (src_beat[i] & {WB_BEAT_W{grant[i]}});
    end
    sel_beat = sel_bits;
  end

  // Next state: lock on a non-eop fire, unlock and step rr_ptr past the grant on eop.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    if (fire) begin
      if (sel_beat.eop) begin
        state_d  = ST_IDLE;
        rr_ptr_d = (grant_idx == IDX_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
      end else begin
        state_d    = ST_LOCKED;
        lock_idx_d = grant_idx;
      end
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

  // Output beat register: fields update only on fire and hold otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      beat_vld_q <= 1'b0;
      beat_q     <= '0;
    end else begin
      beat_vld_q <= fire;
      if (fire) begin
        beat_q <= sel_beat;
      end
    end
  end

  // Beats without a register write are consumed but never presented.
  assign wb_valid = beat_vld_q & beat_q.wb;
  assign wb_uuid  = beat_q.uuid;
  assign wb_wis   = beat_q.wis;
  assign wb_tmask = beat_q.tmask;
  assign wb_pc    = beat_q.pc;
  assign wb_rd    = beat_q.rd;
  assign wb_data  = beat_q.data;
  assign wb_sop   = beat_q.sop;
  assign wb_eop   = beat_q.eop;

`ifdef VX_WB_COMMIT_PERF_EN
  logic multi_vld;
  logic lock_conflict;

  // x & (x-1) is non-zero exactly when two or more bits are set.
  assign multi_vld     = |(src_valid & (src_valid - 1'b1));
  assign lock_conflict = (state_q == ST_LOCKED) && |(src_valid & ~grant);

  // Saturating event counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_commits   <= '0;
      perf_conflicts <= '0;
    end else begin
      if (fire && sel_beat.wb && sel_beat.eop && (perf_commits != '1)) begin
        perf_commits <= perf_commits + 1'b1;
      end
      if ((multi_vld || lock_conflict) && (perf_conflicts != '1)) begin
        perf_conflicts <= perf_conflicts + 1'b1;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  logic [31:0]          stall_cnt;
  logic                 pkt_open;
  logic [`NR_BITS-1:0]  pkt_rd;

  // Track how long a locked source has left its packet hanging.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
    end else if ((state_q == ST_LOCKED) && !src_valid[lock_idx_q]) begin
      stall_cnt <= stall_cnt + 1'b1;
    end else begin
      stall_cnt <= '0;
    end
  end

  // Remember rd of the packet currently leaving on the output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_open <= 1'b0;
      pkt_rd   <= '0;
    end else if (beat_vld_q) begin
      pkt_open <= !beat_q.eop;
      if (!pkt_open) begin
        pkt_rd <= beat_q.rd;
      end
    end
  end

  a_lock_stall : assert property (@(posedge clk) disable iff (!reset_n)
    stall_cnt <= 32'(`STALL_TIMEOUT));

  a_rd_stable : assert property (@(posedge clk) disable iff (!reset_n)
    (beat_vld_q && pkt_open) |-> (beat_q.rd == pkt_rd));
`endif

endmodule

// File: tb/tb_vx_wb_commit.sv
// Scoreboard bench for vx_wb_commit: per-source beat queues drive the inputs,
// hand-ordered expected beats go into a queue, and a monitor compares every
// presented writeback beat against the queue head.
module tb_vx_wb_commit;
  import vx_wb_commit_pkg::*;

  localparam int N  = 4;
  localparam int TC = THREAD_CNT_P;
  localparam int XL = XLEN_P;
  localparam int NR = NR_BITS_P;
  localparam int UW = UUID_W_P;
  localparam int WW = ISSUE_WIS_W;

  typedef struct packed {
    logic [7:0]    tag;
    logic [NR-1:0] rd;
    logic          wb;
    logic          sop;
    logic          eop;
    logic [1:0]    src;
  } tbeat_t;

  typedef struct packed {
    logic [UW-1:0]    uuid;
    logic [WW-1:0]    wis;
    logic [TC-1:0]    tmask;
    logic [XL-1:0]    pc;
    logic [NR-1:0]    rd;
    logic [TC*XL-1:0] data;
    logic             sop;
    logic             eop;
  } exp_t;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [N-1:0]        src_valid, src_ready, src_wb, src_sop, src_eop;
  logic [N*UW-1:0]     src_uuid;
  logic [N*WW-1:0]     src_wis;
  logic [N*TC-1:0]     src_tmask;
  logic [N*XL-1:0]     src_pc;
  logic [N*NR-1:0]     src_rd;
  logic [N*TC*XL-1:0]  src_data;
  logic                wb_valid, wb_sop, wb_eop;
  logic [UW-1:0]       wb_uuid;
  logic [WW-1:0]       wb_wis;
  logic [TC-1:0]       wb_tmask;
  logic [XL-1:0]       wb_pc;
  logic [NR-1:0]       wb_rd;
  logic [TC*XL-1:0]    wb_data;
`ifdef VX_WB_COMMIT_PERF_EN
  logic [43:0]         perf_commits, perf_conflicts;
  logic [43:0]         c0, f0;
`endif

  tbeat_t       srcq [N][$];
  exp_t         expq [$];
  logic [N-1:0] fire_q = '0;
  logic [N-1:0] drv_f;
  tbeat_t       drv_b;
  exp_t         drv_e;
  exp_t         mon_e;
  int           checks = 0;
  int           passes = 0;

  always #5 clk = ~clk;

  vx_wb_commit #(
    .NUM_SRC    (N),
    .THREAD_CNT (TC),
    .WIS_W      (WW),
    .UUID_W     (UW)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .src_valid (src_valid),
    .src_ready (src_ready),
    .src_uuid  (src_uuid),
    .src_wis   (src_wis),
    .src_tmask (src_tmask),
    .src_pc    (src_pc),
    .src_wb    (src_wb),
    .src_rd    (src_rd),
    .src_data  (src_data),
    .src_sop   (src_sop),
    .src_eop   (src_eop),
    .wb_valid  (wb_valid),
    .wb_uuid   (wb_uuid),
    .wb_wis    (wb_wis),
    .wb_tmask  (wb_tmask),
    .wb_pc     (wb_pc),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .wb_sop    (wb_sop),
    .wb_eop    (wb_eop)
`ifdef VX_WB_COMMIT_PERF_EN
    ,
    .perf_commits   (perf_commits),
    .perf_conflicts (perf_conflicts)
`endif
  );

  function automatic exp_t model(input tbeat_t b);
    exp_t e;
    e.uuid  = UW'(b.tag);
    e.wis   = WW'(b.src);
    e.tmask = TC'(b.tag);
    e.pc    = XL'(32'h8000_0000) + XL'({b.tag, 2'b00});
    e.rd    = b.rd;
    for (int l = 0; l < TC; l++) e.data[l*XL +: XL] = XL'({b.tag, 8'(l), 16'hbeef});
    e.sop   = b.sop;
    e.eop   = b.eop;
    return e;
  endfunction

  function automatic tbeat_t mk(input int s, input logic [7:0] tag, input logic [NR-1:0] rd,
                                input logic wb, input logic sop, input logic eop);
    tbeat_t b;
    b.tag = tag; b.rd = rd; b.wb = wb; b.sop = sop; b.eop = eop; b.src = 2'(s);
    return b;
  endfunction

  task automatic send(input int s, input logic [7:0] tag, input logic [NR-1:0] rd,
                      input logic wb, input logic sop, input logic eop);
    srcq[s].push_back(mk(s, tag, rd, wb, sop, eop));
  endtask

  task automatic expect_beat(input int s, input logic [7:0] tag, input logic [NR-1:0] rd,
                             input logic sop, input logic eop);
    expq.push_back(model(mk(s, tag, rd, 1'b1, sop, eop)));
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  function automatic bit busy();
    for (int i = 0; i < N; i++) if (srcq[i].size() > 0) return 1'b1;
    return expq.size() > 0;
  endfunction

  task automatic drain(input string name);
    int n = 0;
    while (busy() && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk(name, {63'd0, busy()}, 64'd0);
  endtask

  // Fire flags are sampled mid-cycle, where inputs and ready are settled.
  always @(negedge clk) fire_q = src_valid & src_ready;

  // Source driver: retire fired beats, then present each queue head.
  initial begin
    src_valid = '0; src_wb = '0; src_sop = '0; src_eop = '0;
    src_uuid = '0; src_wis = '0; src_tmask = '0; src_pc = '0; src_rd = '0; src_data = '0;
    forever begin
      @(posedge clk);
      drv_f = reset_n ? fire_q : '0;
      #1;
      for (int i = 0; i < N; i++) begin
        if (drv_f[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        drv_b = (srcq[i].size() > 0) ? srcq[i][0] : '0;
        drv_e = model(drv_b);
        src_valid[i]              = (srcq[i].size() > 0);
        src_wb[i]                 = drv_b.wb;
        src_sop[i]                = drv_b.sop;
        src_eop[i]                = drv_b.eop;
        src_uuid[i*UW +: UW]      = drv_e.uuid;
        src_wis[i*WW +: WW]       = drv_e.wis;
        src_tmask[i*TC +: TC]     = drv_e.tmask;
        src_pc[i*XL +: XL]        = drv_e.pc;
        src_rd[i*NR +: NR]        = drv_e.rd;
        src_data[i*TC*XL +: TC*XL] = drv_e.data;
      end
    end
  end

  // Monitor: every presented writeback beat must match the scoreboard head.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && wb_valid === 1'b1) begin
      if (expq.size() == 0) begin
        checks++;
        $display("FAIL wb_unexpected: got beat rd=%0h uuid=%0h, expected no beat", wb_rd, wb_uuid);
      end else begin
        mon_e = expq.pop_front();
        chk("wb_rd",    64'(wb_rd),    64'(mon_e.rd));
        chk("wb_uuid",  64'(wb_uuid),  64'(mon_e.uuid));
        chk("wb_wis",   64'(wb_wis),   64'(mon_e.wis));
        chk("wb_tmask", 64'(wb_tmask), 64'(mon_e.tmask));
        chk("wb_pc",    64'(wb_pc),    64'(mon_e.pc));
        chk("wb_data",  64'(wb_data),  64'(mon_e.data));
        chk("wb_sop",   64'(wb_sop),   64'(mon_e.sop));
        chk("wb_eop",   64'(wb_eop),   64'(mon_e.eop));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n = 1'b0;

    // Reset with every source valid; then round-robin over single-beat packets.
    @(negedge clk); #1;
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < N; i++) begin
        send(i, 8'(16*r + i), NR'(i), 1'b1, 1'b1, 1'b1);
        expect_beat(i, 8'(16*r + i), NR'(i), 1'b1, 1'b1);
      end
    repeat (3) @(negedge clk);
    chk("reset_ready", 64'(src_ready), 64'h0);
    chk("reset_wb_valid", 64'(wb_valid), 64'h0);
    chk("reset_wb_rd", 64'(wb_rd), 64'h0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("first_grant_ready", 64'(src_ready), 64'b0001);
    chk("first_grant_latency", 64'(wb_valid), 64'h0);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("rr_stream_valid", 64'(wb_valid), 64'h1);
    end
    drain("drain_rr");

    // wb=0 eop beat from src1: accepted, never presented, rr_ptr moves to 2.
    @(negedge clk); #1;
    send(1, 8'h40, NR'(1), 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chk("nowb_ready", 64'(src_ready), 64'b0010);
    @(negedge clk);
    chk("nowb_wb_valid", 64'(wb_valid), 64'h0);
    chk("nowb_consumed", 64'(srcq[1].size()), 64'h0);

    // Locked 3-beat packet from src2 with all others valid; then src3, src0, src1.
    @(negedge clk); #1;
    send(0, 8'h50, NR'(10), 1'b1, 1'b1, 1'b1);
    send(1, 8'h51, NR'(11), 1'b1, 1'b1, 1'b1);
    send(2, 8'h60, NR'(12), 1'b1, 1'b1, 1'b0);
    send(2, 8'h61, NR'(12), 1'b1, 1'b0, 1'b0);
    send(2, 8'h62, NR'(12), 1'b1, 1'b0, 1'b1);
    send(3, 8'h70, NR'(13), 1'b1, 1'b1, 1'b1);
    expect_beat(2, 8'h60, NR'(12), 1'b1, 1'b0);
    expect_beat(2, 8'h61, NR'(12), 1'b0, 1'b0);
    expect_beat(2, 8'h62, NR'(12), 1'b0, 1'b1);
    expect_beat(3, 8'h70, NR'(13), 1'b1, 1'b1);
    expect_beat(0, 8'h50, NR'(10), 1'b1, 1'b1);
    expect_beat(1, 8'h51, NR'(11), 1'b1, 1'b1);
    @(negedge clk);
    chk("lock_first_ready", 64'(src_ready), 64'b0100);
    @(negedge clk);
    chk("locked_ready", 64'(src_ready), 64'b0100);
    drain("drain_lock3");

    // rr_ptr is 2: src2 2-beat packet, src3 idle, so src0 follows.
    @(negedge clk); #1;
    send(0, 8'h80, NR'(14), 1'b1, 1'b1, 1'b1);
    send(2, 8'h81, NR'(15), 1'b1, 1'b1, 1'b0);
    send(2, 8'h82, NR'(15), 1'b1, 1'b0, 1'b1);
    expect_beat(2, 8'h81, NR'(15), 1'b1, 1'b0);
    expect_beat(2, 8'h82, NR'(15), 1'b0, 1'b1);
    expect_beat(0, 8'h80, NR'(14), 1'b1, 1'b1);
    drain("drain_lock2");

    // rr_ptr is 1: src2 granted; reset after its first beat drops the second.
    @(negedge clk); #1;
    send(2, 8'h90, NR'(16), 1'b1, 1'b1, 1'b0);
    send(2, 8'h91, NR'(16), 1'b1, 1'b0, 1'b1);
    expect_beat(2, 8'h90, NR'(16), 1'b1, 1'b0);
    n = 0;
    while (wb_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("midpkt_beat1_seen", 64'(wb_valid), 64'h1);
    #1 reset_n = 1'b0;
    srcq[2].delete();
    #1;
    chk("midpkt_reset_valid", 64'(wb_valid), 64'h0);
    chk("midpkt_reset_ready", 64'(src_ready), 64'h0);
    chk("midpkt_reset_eop", 64'(wb_eop), 64'h0);
    send(0, 8'hA0, NR'(17), 1'b1, 1'b1, 1'b1);
    send(2, 8'hA2, NR'(18), 1'b1, 1'b1, 1'b1);
    expect_beat(0, 8'hA0, NR'(17), 1'b1, 1'b1);
    expect_beat(2, 8'hA2, NR'(18), 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_grant", 64'(src_ready), 64'b0001);
    drain("drain_reset");

    // rr_ptr is 3: two contending sources, five single-beat commits each.
`ifdef VX_WB_COMMIT_PERF_EN
    c0 = perf_commits;
    f0 = perf_conflicts;
`endif
    #1;
    for (int k = 0; k < 5; k++) begin
      send(0, 8'(8'hB0 + k), NR'(20), 1'b1, 1'b1, 1'b1);
      send(1, 8'(8'hC0 + k), NR'(21), 1'b1, 1'b1, 1'b1);
      expect_beat(0, 8'(8'hB0 + k), NR'(20), 1'b1, 1'b1);
      expect_beat(1, 8'(8'hC0 + k), NR'(21), 1'b1, 1'b1);
    end
    drain("drain_pair");
`ifdef VX_WB_COMMIT_PERF_EN
    chk("perf_commits", 64'(perf_commits - c0), 64'd10);
    chk("perf_conflicts", 64'(perf_conflicts - f0), 64'd9);
`endif

    chk("scoreboard_empty", 64'(expq.size()), 64'h0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
